// File: rtl/sd_bist_pkg.sv
// Shared types and constants for the SD block self-test sequencer.
package sd_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_ACK,
        W_DATA,
        R_WAIT,
        R_ACK,
        R_DATA,
        FINISH
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_XOR   = 2'd3
    } mode_e;

    localparam logic [7:0]  PAT_CONST      = 8'hAA;
    localparam logic [7:0]  LFSR_SEED      = 8'h01;
    // Feedback bits 7,5,4,3 of the left-shifting Fibonacci LFSR.
    localparam logic [7:0]  LFSR_TAPS      = 8'hB8;
    localparam logic [31:0] FIRST_ERR_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/sd_pattern_gen.sv
// Test byte generator shared by the write and read phases of the BIST.
module sd_pattern_gen
    import sd_bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        advance,
    input  logic [1:0]  mode,
    input  logic [15:0] block_idx,
    input  logic [15:0] byte_idx,
    output logic [7:0]  pat
);

    logic [7:0] lfsr;

    // The LFSR only moves on consumed bytes, so it runs on across block boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (restart) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_comb begin
        pat = PAT_CONST;
        case (mode_e'(mode))
            MODE_CONST: pat = PAT_CONST;
            MODE_INC:   pat = byte_idx[7:0];
            MODE_LFSR:  pat = lfsr;
            MODE_XOR:   pat = block_idx[7:0] ^ byte_idx[7:0];
            default:    pat = PAT_CONST;
        endcase
    end

endmodule

// File: rtl/sd_block_bist.sv
// Write-then-readback self-test sequencer driving the SPI-mode sd_controller.
module sd_block_bist
    import sd_bist_pkg::*;
#(
    parameter int NBLOCKS     = 4,
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_STEP   = 512,
    parameter int ERRW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [31:0]     base_addr,
    input  logic            sd_ready,
    input  logic            sd_ready_for_next_byte,
    input  logic            sd_byte_available,
    input  logic [7:0]      sd_dout,
    output logic            sd_rd,
    output logic            sd_wr,
    output logic [7:0]      sd_din,
    output logic [31:0]     sd_address,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [31:0]     first_err
);

    localparam logic [15:0]     BB       = 16'(BLOCK_BYTES);
    localparam logic [15:0]     LAST_BLK = 16'(NBLOCKS - 1);
    localparam logic [31:0]     STEP     = 32'(ADDR_STEP);
    localparam int              SW       = ERRW + 18;
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    state_e      state;
    logic [1:0]  mode_q;
    logic [31:0] base_q;
    logic [15:0] blk_idx;
    logic [15:0] byte_idx;
    logic        rfnb_q;
    logic        bav_q;
    logic [7:0]  pat;

    logic          advance;
    logic          mismatch;
    logic          blk_end;
    logic          last_blk;
    logic          restart;
    logic [15:0]   cnt_next;
    logic [15:0]   missing;
    logic [SW-1:0] err_sum;
    logic [ERRW-1:0] err_next;
    logic [31:0]   first_next;

    sd_pattern_gen u_pat (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .advance   (advance),
        .mode      (mode_q),
        .block_idx (blk_idx),
        .byte_idx  (byte_idx),
        .pat       (pat)
    );

    // A strobe edge coinciding with sd_ready rising is counted before the block closes.
    always_comb begin
        advance  = (byte_idx < BB) &&
                   (((state == W_DATA) && sd_ready_for_next_byte && !rfnb_q) ||
                    ((state == R_DATA) && sd_byte_available && !bav_q));
        cnt_next = byte_idx + 16'(advance);
        mismatch = (state == R_DATA) && advance && (sd_dout != pat);
        blk_end  = sd_ready && ((state == W_DATA) || (state == R_DATA));
        last_blk = (blk_idx == LAST_BLK);
        restart  = ((state == IDLE) && start) || ((state == W_DATA) && blk_end && last_blk);
        missing  = ((state == R_DATA) && blk_end && (cnt_next < BB)) ? (BB - cnt_next) : '0;
        err_sum  = SW'(err_count) + SW'(mismatch) + SW'(missing);
        err_next = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERRW-1:0];
        first_next = first_err;
        // A zero error count means no failing location has been captured yet.
        if (err_count == '0) begin
            if (mismatch) begin
                first_next = {blk_idx, byte_idx};
            end else if (missing != '0) begin
                first_next = {blk_idx, cnt_next};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= '0;
            base_q     <= '0;
            blk_idx    <= '0;
            byte_idx   <= '0;
            rfnb_q     <= 1'b0;
            bav_q      <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_din     <= '0;
            sd_address <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_err  <= FIRST_ERR_NONE;
        end else begin
            rfnb_q <= sd_ready_for_next_byte;
            bav_q  <= sd_byte_available;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= W_WAIT;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_err  <= FIRST_ERR_NONE;
                        mode_q     <= mode;
                        base_q     <= base_addr;
                        sd_address <= base_addr;
                        blk_idx    <= '0;
                        byte_idx   <= '0;
                    end
                end
                W_WAIT: begin
                    sd_din <= pat;
                    if (sd_ready) begin
                        sd_wr <= 1'b1;
                        state <= W_ACK;
                    end
                end
                W_ACK: begin
                    if (!sd_ready) begin
                        sd_wr <= 1'b0;
                        state <= W_DATA;
                    end
                end
                W_DATA: begin
                    sd_din <= pat;
                    if (advance) byte_idx <= cnt_next;
                    if (blk_end) begin
                        byte_idx <= '0;
                        if (last_blk) begin
                            blk_idx    <= '0;
                            sd_address <= base_q;
                            state      <= R_WAIT;
                        end else begin
                            blk_idx    <= blk_idx + 16'd1;
                            sd_address <= sd_address + STEP;
                            state      <= W_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (sd_ready) begin
                        sd_rd <= 1'b1;
                        state <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!sd_ready) begin
                        sd_rd <= 1'b0;
                        state <= R_DATA;
                    end
                end
                R_DATA: begin
                    err_count <= err_next;
                    first_err <= first_next;
                    if (advance) byte_idx <= cnt_next;
                    if (blk_end) begin
                        byte_idx <= '0;
                        if (last_blk) begin
                            state <= FINISH;
                        end else begin
                            blk_idx    <= blk_idx + 16'd1;
                            sd_address <= sd_address + STEP;
                            state      <= R_WAIT;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_bist.sv
// Randomised scoreboard bench for sd_block_bist against a behavioural SD controller model.
module tb_sd_block_bist;

    localparam int NB   = 2;
    localparam int BB   = 512;
    localparam int STEP = 512;
    localparam int EW   = 4;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        pass;
        logic [EW-1:0] err;
        logic [31:0] fe;
    } res_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [31:0]   base_addr;
    logic          sd_ready;
    logic          rfnb;
    logic          bav;
    logic [7:0]    sd_dout;
    logic          sd_rd;
    logic          sd_wr;
    logic [7:0]    sd_din;
    logic [31:0]   sd_address;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [31:0]   first_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_bytes = 0;
    int cur_mode = 0;
    int nread[NB];
    int flip[NB];
    logic [7:0]  lfsr_seq[NB*BB];
    logic [7:0]  exp_wr[$];
    logic [32:0] exp_addr[$];
    res_t        exp_res[$];

    sd_block_bist #(
        .NBLOCKS(NB),
        .BLOCK_BYTES(BB),
        .ADDR_STEP(STEP),
        .ERRW(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .base_addr(base_addr),
        .sd_ready(sd_ready),
        .sd_ready_for_next_byte(rfnb),
        .sd_byte_available(bav),
        .sd_dout(sd_dout),
        .sd_rd(sd_rd),
        .sd_wr(sd_wr),
        .sd_din(sd_din),
        .sd_address(sd_address),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err(first_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected byte of the test stream for block b, byte i.
    function automatic logic [7:0] ref_pat(input int md, input int b, input int i);
        logic [7:0] bb8;
        logic [7:0] ii8;
        bb8 = 8'(b);
        ii8 = 8'(i);
        case (md)
            0:       return 8'hAA;
            1:       return ii8;
            2:       return lfsr_seq[b*BB + i];
            default: return bb8 ^ ii8;
        endcase
    endfunction

    function automatic int pick_n(input int md);
        int s;
        s = $urandom_range(0, 3);
        if (s == 0 && md != 2) return BB - $urandom_range(1, 20);
        if (s == 1) return BB + $urandom_range(1, 3);
        return BB;
    endfunction

    task automatic setup(input int md, input logic [31:0] ba, input int n0, input int n1,
                         input int f0, input int f1);
        cur_mode  = md;
        mode      = 2'(md);
        base_addr = ba;
        nread[0]  = n0;
        nread[1]  = n1;
        flip[0]   = f0;
        flip[1]   = f1;
    endtask

    task automatic issue_expect();
        int   errs;
        int   lim;
        logic found;
        res_t r;
        errs  = 0;
        found = 1'b0;
        r.fe  = NONE;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < BB; i++)
                exp_wr.push_back(ref_pat(cur_mode, b, i));
        for (int b = 0; b < NB; b++) exp_addr.push_back({1'b0, base_addr + 32'(b*STEP)});
        for (int b = 0; b < NB; b++) exp_addr.push_back({1'b1, base_addr + 32'(b*STEP)});
        for (int b = 0; b < NB; b++) begin
            lim = (nread[b] < BB) ? nread[b] : BB;
            if (flip[b] >= 0 && flip[b] < lim) begin
                errs++;
                if (!found) begin r.fe = {16'(b), 16'(flip[b])}; found = 1'b1; end
            end
            if (nread[b] < BB) begin
                if (!found) begin r.fe = {16'(b), 16'(nread[b])}; found = 1'b1; end
                errs += BB - nread[b];
            end
        end
        r.err  = (errs > 15) ? 4'hF : 4'(errs);
        r.pass = (errs == 0);
        exp_res.push_back(r);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", (done_cnt >= target), 1);
    endtask

    task automatic run_test(input int md, input logic [31:0] ba, input int n0, input int n1,
                            input int f0, input int f1);
        int target;
        setup(md, ba, n0, n1, f0, f1);
        issue_expect();
        target = done_cnt + 1;
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_done(target);
        repeat (3) @(negedge clk);
    endtask

    // Controller model: write side.
    task automatic write_block();
        int b;
        int bad;
        int first_bad;
        logic aborted;
        logic [7:0] e;
        b = wr_cnt % NB;
        bad = 0;
        first_bad = -1;
        aborted = 1'b0;
        sd_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < BB; i++) begin
            if (reset) begin aborted = 1'b1; break; end
            e = (exp_wr.size() > 0) ? exp_wr.pop_front() : ~sd_din;
            if (sd_din !== e) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            wr_bytes++;
            rfnb = 1'b1;
            @(negedge clk);
            rfnb = 1'b0;
            @(negedge clk);
        end
        if (!aborted && !reset) begin
            check($sformatf("wr_data_blk%0d_first_bad_%0d", b, first_bad), bad, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wr_cnt++;
        end
        sd_ready = 1'b1;
    endtask

    // Controller model: read side, with optional corrupt, short or overlong blocks.
    task automatic read_block();
        int b;
        logic aborted;
        b = rd_cnt % NB;
        aborted = 1'b0;
        sd_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < nread[b]; i++) begin
            if (reset) begin aborted = 1'b1; break; end
            if (i < BB) sd_dout = ref_pat(cur_mode, b, i) ^ ((i == flip[b]) ? 8'h80 : 8'h00);
            else        sd_dout = 8'($urandom);
            bav = 1'b1;
            @(negedge clk);
            bav = 1'b0;
            @(negedge clk);
        end
        if (!aborted && !reset) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rd_cnt++;
        end
        sd_ready = 1'b1;
    endtask

    initial begin
        sd_ready = 1'b1;
        rfnb     = 1'b0;
        bav      = 1'b0;
        sd_dout  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sd_wr)      write_block();
                else if (sd_rd) read_block();
            end
        end
    end

    // Monitor: command addresses and end-of-test results.
    initial begin
        logic wr_prev;
        logic rd_prev;
        logic [32:0] ea;
        res_t r;
        wr_prev = 1'b0;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((sd_wr && !wr_prev) || (sd_rd && !rd_prev)) begin
                    check("cmd_expected", exp_addr.size() != 0, 1);
                    if (exp_addr.size() != 0) begin
                        ea = exp_addr.pop_front();
                        check(sd_rd ? "rd_addr" : "wr_addr", {sd_rd, sd_address}, ea);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_expected", exp_res.size() != 0, 1);
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        check("pass", pass, r.pass);
                        check("err_count", err_count, r.err);
                        check("first_err", first_err, r.fe);
                    end
                end
            end
            wr_prev = sd_wr;
            rd_prev = sd_rd;
        end
    end

    initial begin
        logic [7:0] v;
        int target;
        int t;
        int md;
        int wb0;

        v = 8'h01;
        for (int k = 0; k < NB*BB; k++) begin
            lfsr_seq[k] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end

        reset     = 1'b1;
        start     = 1'b0;
        mode      = '0;
        base_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_sd_wr", sd_wr, 0);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err", first_err, NONE);
        check("rst_sd_address", sd_address, 0);
        check("rst_sd_din", sd_din, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_test(0, 32'h0000_0000, BB, BB, -1, -1);
        run_test(1, 32'h0000_1000, BB, BB, -1, -1);
        run_test(2, 32'h0002_0000, BB, BB, -1, 3);
        run_test(3, 32'h0000_0400, 500, BB, -1, -1);
        run_test(3, 32'h0000_0800, BB + 2, BB - 3, 5, -1);

        // Asynchronous reset while write data is streaming.
        setup(1, 32'h0000_4000, BB, BB, -1, -1);
        issue_expect();
        wb0 = wr_bytes;
        pulse_start();
        t = 0;
        while (wr_bytes < wb0 + 100 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reached_w_data", (wr_bytes >= wb0 + 100), 1);
        check("busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sd_wr", sd_wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sd_din", sd_din, 0);
        check("mid_rst_sd_address", sd_address, 0);
        check("mid_rst_first_err", first_err, NONE);
        repeat (3) @(negedge clk);
        exp_wr.delete();
        exp_addr.delete();
        exp_res.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_test(2, 32'h0000_8000, BB, BB, -1, -1);

        // Extra start pulse while busy must be ignored.
        setup(0, 32'h0001_0000, BB, BB, -1, -1);
        issue_expect();
        target = done_cnt + 1;
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        wait_done(target);
        repeat (30) @(negedge clk);
        check("single_done", done_cnt, target);
        check("idle_after_single", busy, 0);

        // Held start re-runs immediately with a cleared error count.
        setup(2, 32'h0000_2000, BB, BB, 7, -1);
        issue_expect();
        issue_expect();
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b1;
        wait_done(target);
        t = 0;
        while (!busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("rerun_busy", busy, 1);
        check("rerun_err_cleared", err_count, 0);
        start = 1'b0;
        wait_done(target + 1);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            md = $urandom_range(0, 3);
            run_test(md, $urandom, pick_n(md), pick_n(md),
                     ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, BB - 1)),
                     ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, BB - 1)));
        end

        check("res_left", exp_res.size(), 0);
        check("addr_left", exp_addr.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_block_bist.md
# sd_block_bist

Parametrised built-in self-test sequencer for the SPI-mode `sd_controller`. It writes a run of `NBLOCKS` consecutive blocks with a selectable byte pattern, then reads the same blocks back. The read data is checked against a regenerated pattern, and the block reports pass/fail, an error count and the first failing location. It sits between a board top (buttons/LEDs) and `sd_controller`, in the same clock domain as the controller.

## Interface
Parameters:
- `NBLOCKS`, 4: number of consecutive blocks per test (1..65535).
- `BLOCK_BYTES`, 512: bytes per block expected by the controller.
- `ADDR_STEP`, 512: increment applied to `sd_address` between blocks.
- `ERRW`, 16: width of the error counter.

Ports:
- `clk` in 1: controller clock (25 MHz on board).
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: level; sampled only in IDLE.
- `mode` in 2: pattern select, latched at start. 0 = const 0xAA, 1 = incrementing, 2 = LFSR, 3 = block^byte.
- `base_addr` in 32: first block address, latched at start.
- `sd_ready`, `sd_ready_for_next_byte`, `sd_byte_available` in 1 each: from the controller.
- `sd_dout` in 8: read byte from the controller.
- `sd_rd`, `sd_wr` out 1 each: controller commands.
- `sd_din` out 8: write byte to the controller.
- `sd_address` out 32: current block address.
- `busy` out 1: high from accept of `start` until `done`.
- `done` out 1: one-cycle pulse at test end.
- `pass` out 1: valid after `done`; held until the next accepted start.
- `err_count` out ERRW: saturating mismatch count.
- `first_err` out 32: {block index[15:0], byte index[15:0]} of the first mismatch; 0xFFFF_FFFF if there was none.

## Operation
- Reset values:
  - `sd_rd`, `sd_wr`, `busy`, `done`, `pass`, `err_count`: 0.
  - `sd_din`: 0.
  - `sd_address`: 0.
  - `first_err`: 0xFFFF_FFFF.
  - State: IDLE.
- States and transitions:
  - IDLE → W_WAIT on `start`. This clears the counters and `pass`, latches `mode` and `base_addr`, and sets the phase to write.
  - W_WAIT: wait for `sd_ready`, then assert `sd_wr` with `sd_din` = pattern byte 0 → W_ACK.
  - W_ACK: on `sd_ready`=0, drop `sd_wr` → W_DATA.
  - W_DATA: on each rising edge of `sd_ready_for_next_byte`, advance the byte index and present the next pattern byte. When `sd_ready` returns high, the block is done.
    - If more blocks remain: advance the block index, `sd_address` += `ADDR_STEP`, and go to W_WAIT.
    - After the last block: reset the indices and pattern, set `sd_address` = base, and go to R_WAIT.
  - R_WAIT / R_ACK: same handshake as write, using `sd_rd`.
  - R_DATA: on each rising edge of `sd_byte_available`, compare `sd_dout` with the pattern byte and advance. When `sd_ready` returns high, the block ends; move to the next block or to FINISH.
  - FINISH: `done`=1 for one cycle, `pass` = (`err_count`==0), `busy`=0 → IDLE.
- Pattern generation (restarted at the start of each phase, so the read phase regenerates the write stream exactly):
  - Mode 0: 0xAA.
  - Mode 1: byte index[7:0], restarting at 0 each block.
  - Mode 2: 8-bit Fibonacci LFSR, seed 0x01, left shift, new bit = b7^b5^b4^b3. Runs continuously across blocks.
  - Mode 3: block index[7:0] ^ byte index[7:0].
- Errors:
  - Each mismatching byte adds 1 to `err_count`, saturating at all-ones.
  - `first_err` is captured only once per test.
  - Short read block (`sd_ready` rises with byte count < `BLOCK_BYTES`): add the number of missing bytes, saturating. `first_err` is set to the first missing index if still unset.
  - Bytes beyond `BLOCK_BYTES` in a block are ignored.

## Timing
- `start` acceptance to `sd_wr` assertion: 1 cycle if `sd_ready` is already high.
- Byte-edge detection uses a 1-cycle registered copy of each strobe. `sd_din` updates on the cycle after the edge is seen, which is within the controller's byte period at SPI rates.
- Compare result lands in `err_count` 1 cycle after the `sd_byte_available` edge.
- `done` asserts 1 cycle after the last read block ends.
- `start` held high re-runs the test after `done`. `start` while `busy` is ignored.
- Simultaneous strobe edge and `sd_ready` rise: the byte is counted first, then the block end is processed.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); no partial result is reported.

## Structure
- Package `sd_bist_pkg`:
  - State enum.
  - Mode codes.
  - `PAT_CONST` = 8'hAA.
  - LFSR seed and taps.
  - `FIRST_ERR_NONE` = 32'hFFFF_FFFF.
- Sub-module `sd_pattern_gen`: inputs `clk`, `reset`, `restart`, `advance`, `mode`, `block_idx`, `byte_idx`; output `pat` [7:0]. It is shared by both phases.

## Test plan
- Mode 0, NBLOCKS=1, echoing controller model → 512 writes of 0xAA at address 0; `done` pulses, `pass`=1, `err_count`=0.
- Mode 1, NBLOCKS=2, `base_addr`=0x1000 → addresses 0x1000 then 0x1200; each block carries bytes 0..255,0..255; `pass`=1.
- Mode 2, model flips byte 3 of block 1 on read → `err_count`=1, `first_err`=0x0001_0003, `pass`=0.
- Mode 3, model delivers only 500 bytes of read block 0 → `err_count`=12, `first_err`=0x0000_01F4.
- `reset` asserted mid W_DATA → `sd_wr`=0 and `busy`=0 in the same cycle; a following `start` completes with `pass`=1.
- `start` pulsed again while `busy` → ignored, exactly one `done`; `start` held high → second run follows, with `err_count` cleared at its start.
